// File: rtl/id_ex_register_if.sv
// ID/EX boundary bundle: decoded ID fields, write-back port, pipeline control and registered EX view.
interface id_ex_register_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned COUNT_WIDTH    = 16
);
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_read_register_1;
  logic [REG_ADDR_WIDTH-1:0] id_read_register_2;
  logic                      id_uses_rs;
  logic                      id_uses_rt;
  logic [DATA_WIDTH-1:0]     id_read_data_1;
  logic [DATA_WIDTH-1:0]     id_read_data_2;
  logic [REG_ADDR_WIDTH-1:0] id_write_register;
  logic [DATA_WIDTH-1:0]     id_immediate;
  logic [DATA_WIDTH-1:0]     id_pc_plus4;
  logic                      id_register_write;
  logic                      id_memory_read;
  logic                      id_memory_write;
  logic                      id_memory_to_register;
  logic                      id_alu_source;
  logic [3:0]                id_alu_op;

  logic                      wb_register_write;
  logic [REG_ADDR_WIDTH-1:0] wb_write_register;
  logic [DATA_WIDTH-1:0]     wb_write_data;

  logic                      ex_flush;
  logic                      ex_hold;

  logic                      ex_valid;
  logic [REG_ADDR_WIDTH-1:0] ex_read_register_1;
  logic [REG_ADDR_WIDTH-1:0] ex_read_register_2;
  logic [DATA_WIDTH-1:0]     ex_read_data_1;
  logic [DATA_WIDTH-1:0]     ex_read_data_2;
  logic [REG_ADDR_WIDTH-1:0] ex_write_register;
  logic [DATA_WIDTH-1:0]     ex_immediate;
  logic [DATA_WIDTH-1:0]     ex_pc_plus4;
  logic                      ex_register_write;
  logic                      ex_memory_read;
  logic                      ex_memory_write;
  logic                      ex_memory_to_register;
  logic                      ex_alu_source;
  logic [3:0]                ex_alu_op;

  logic                      hazard_stall;
  logic [COUNT_WIDTH-1:0]    bubble_count;

  modport master (
    output id_valid, id_read_register_1, id_read_register_2, id_uses_rs, id_uses_rt,
           id_read_data_1, id_read_data_2, id_write_register, id_immediate, id_pc_plus4,
           id_register_write, id_memory_read, id_memory_write, id_memory_to_register,
           id_alu_source, id_alu_op, wb_register_write, wb_write_register, wb_write_data,
           ex_flush, ex_hold,
    input  ex_valid, ex_read_register_1, ex_read_register_2, ex_read_data_1, ex_read_data_2,
           ex_write_register, ex_immediate, ex_pc_plus4, ex_register_write, ex_memory_read,
           ex_memory_write, ex_memory_to_register, ex_alu_source, ex_alu_op,
           hazard_stall, bubble_count
  );

  modport slave (
    input  id_valid, id_read_register_1, id_read_register_2, id_uses_rs, id_uses_rt,
           id_read_data_1, id_read_data_2, id_write_register, id_immediate, id_pc_plus4,
           id_register_write, id_memory_read, id_memory_write, id_memory_to_register,
           id_alu_source, id_alu_op, wb_register_write, wb_write_register, wb_write_data,
           ex_flush, ex_hold,
    output ex_valid, ex_read_register_1, ex_read_register_2, ex_read_data_1, ex_read_data_2,
           ex_write_register, ex_immediate, ex_pc_plus4, ex_register_write, ex_memory_read,
           ex_memory_write, ex_memory_to_register, ex_alu_source, ex_alu_op,
           hazard_stall, bubble_count
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion and a saturating bubble counter.
module id_ex_register #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input logic            clk,
  input logic            reset,
  id_ex_register_if.slave bus
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic                  hazard;
  logic                  update;
  logic                  take;
  logic                  bypass_1;
  logic                  bypass_2;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;

  // Load in EX whose destination is consumed by the instruction now in ID.
  always_comb begin
    hazard = bus.id_valid && bus.ex_valid && bus.ex_memory_read &&
             (bus.ex_write_register != '0) &&
             ((bus.id_uses_rs && (bus.ex_write_register == bus.id_read_register_1)) ||
              (bus.id_uses_rt && (bus.ex_write_register == bus.id_read_register_2)));
  end

  assign bus.hazard_stall = hazard;

  // RegisterFile commits on the same edge, so its read port still shows the old value.
  always_comb begin
    bypass_1  = bus.wb_register_write && (bus.wb_write_register != '0) &&
                (bus.wb_write_register == bus.id_read_register_1);
    bypass_2  = bus.wb_register_write && (bus.wb_write_register != '0) &&
                (bus.wb_write_register == bus.id_read_register_2);
    operand_1 = bypass_1 ? bus.wb_write_data : bus.id_read_data_1;
    operand_2 = bypass_2 ? bus.wb_write_data : bus.id_read_data_2;
  end

  // Hold only freezes when nothing stronger applies; anything but a clean capture is a bubble.
  always_comb begin
    update = reset || bus.ex_flush || !bus.ex_hold;
    take   = !reset && !bus.ex_flush && !hazard && bus.id_valid;
  end

  always_ff @(posedge clk) begin
    if (update) begin
      bus.ex_valid              <= take;
      bus.ex_read_register_1    <= take ? bus.id_read_register_1    : '0;
      bus.ex_read_register_2    <= take ? bus.id_read_register_2    : '0;
      bus.ex_read_data_1        <= take ? operand_1                 : '0;
      bus.ex_read_data_2        <= take ? operand_2                 : '0;
      bus.ex_write_register     <= take ? bus.id_write_register     : '0;
      bus.ex_immediate          <= take ? bus.id_immediate          : '0;
      bus.ex_pc_plus4           <= take ? bus.id_pc_plus4           : '0;
      bus.ex_register_write     <= take && bus.id_register_write;
      bus.ex_memory_read        <= take && bus.id_memory_read;
      bus.ex_memory_write       <= take && bus.id_memory_write;
      bus.ex_memory_to_register <= take && bus.id_memory_to_register;
      bus.ex_alu_source         <= take && bus.id_alu_source;
      bus.ex_alu_op             <= take ? bus.id_alu_op             : 4'h0;
    end
  end

  // Counts only bubbles caused by the hazard itself, never flush or hold cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.bubble_count <= '0;
    end else if (!bus.ex_flush && !bus.ex_hold && hazard && (bus.bubble_count != COUNT_MAX)) begin
      bus.bubble_count <= bus.bubble_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- ID/EX pipeline register of the pipelined MIPS core. It sits directly downstream of RegisterFile.
- Captures the RegisterFile read data, decoded fields and control bits each cycle for the EX stage.
- Forwards the same-cycle write-back value around the RegisterFile, because RegisterFile writes on the clock edge.
- Detects load-use hazards, inserts bubbles, honours flush/hold, and counts inserted hazard bubbles.

Parameters:
DATA_WIDTH, 32, width of register data, immediate and PC
REG_ADDR_WIDTH, 5, register index width
COUNT_WIDTH, 16, width of the hazard bubble counter

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
id_valid  input  1  ID slot holds a real instruction
id_read_register_1 / id_read_register_2  input  REG_ADDR_WIDTH  rs / rt indices driven to RegisterFile
id_uses_rs / id_uses_rt  input  1  instruction actually consumes rs / rt
id_read_data_1 / id_read_data_2  input  DATA_WIDTH  RegisterFile read_data_1 / read_data_2
id_write_register  input  REG_ADDR_WIDTH  destination (post RegDst mux)
id_immediate  input  DATA_WIDTH  sign-extended immediate
id_pc_plus4  input  DATA_WIDTH  PC+4
id_register_write, id_memory_read, id_memory_write, id_memory_to_register, id_alu_source  input  1 each  control bits
id_alu_op  input  4  ALU operation
wb_register_write  input  1  write-back enable (same signal as RegisterFile register_write)
wb_write_register  input  REG_ADDR_WIDTH  write-back index
wb_write_data  input  DATA_WIDTH  write-back data
ex_flush  input  1  squash (branch taken)
ex_hold  input  1  downstream stall; freeze contents
ex_* outputs  output  widths as id_* counterparts  registered copies: ex_valid, ex_read_register_1/2, ex_read_data_1/2, ex_write_register, ex_immediate, ex_pc_plus4, five control bits, ex_alu_op
hazard_stall  output  1  combinational load-use stall to PC and IF/ID
bubble_count  output  COUNT_WIDTH  saturating count of hazard bubbles

Behaviour:
- Reset (synchronous): every ex_* output and bubble_count go to 0. hazard_stall is combinational from ex_* state, so it reads 0 in the cycle after reset.
- hazard_stall = id_valid & ex_valid & ex_memory_read & (ex_write_register != 0) & ((id_uses_rs & ex_write_register == id_read_register_1) | (id_uses_rt & ex_write_register == id_read_register_2)).
- Bypass, per operand n: if wb_register_write & wb_write_register != 0 & wb_write_register == id_read_register_n, capture wb_write_data; otherwise capture id_read_data_n. Index 0 is never bypassed.
- Edge update priority, highest first:
  1. reset
  2. ex_flush: load bubble
  3. ex_hold: keep all ex_* unchanged
  4. hazard_stall: load bubble and increment bubble_count
  5. otherwise load ID fields
- A bubble is ex_valid=0 with all control bits, ex_alu_op, indices and data at 0.
- id_valid=0 in the load case loads a bubble and does not increment the counter.
- Latency: one cycle from ID inputs to ex_* outputs.
- bubble_count increments only in priority case 4. It saturates at 2^COUNT_WIDTH-1 and never wraps.
- Flush during a hazard: the flush bubble is loaded and the counter is not incremented.
- Hold during a hazard: contents are frozen, the counter is not incremented, and hazard_stall stays asserted.

Test Plan:
- Reset: assert reset for 2 cycles with random ID inputs -> all ex_* = 0, bubble_count = 0, hazard_stall = 0.
- Capture: id_valid=1, rs=3, rt=4, read data 0x11111111 / 0x22222222, alu_op=4'h2, no WB -> next cycle ex_read_data_1=0x11111111, ex_read_data_2=0x22222222, ex_valid=1, ex_alu_op=4'h2.
- Bypass: wb_register_write=1, wb_write_register=1, wb_write_data=0xFFDDABCC, rs=1, id_read_data_1=0 -> ex_read_data_1=0xFFDDABCC.
- Bypass on index 0: same with wb_write_register=0 and rs=0 -> ex_read_data_1=0.
- Load-use: load r2 (memory_read=1, write_register=2) followed by an instruction with rt=2, id_uses_rt=1 -> hazard_stall=1, next cycle ex_valid=0, bubble_count=1. With the ID inputs held, the following cycle ex_valid=1 and hazard_stall=0.
- Priority and saturation:
  - ex_flush=1 with ex_hold=1 -> bubble loaded.
  - ex_hold=1 alone -> ex_* unchanged for 3 cycles.
  - 65540 consecutive hazards with COUNT_WIDTH=16 -> bubble_count stays at 0xFFFF.
